// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline register for the 16-bit, 16-register pipeline.
//
// Captures the fetched instruction and its PC+2. The register honours the
// decode-stage stall and branch flush, freezes on a valid HLT, and drives
// the PC write enable. It decodes the register fields and the branch/load
// flags used by the hazard unit and the register file. A saturating
// stall-cycle counter is kept for debug.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   if_instr            instruction fetched this cycle
//   if_pc_plus2         PC+2 of the fetched instruction
//   stall               hold request from the data-hazard unit
//   flush               squash request from a taken branch
//   cnt_clr             synchronous clear of stall_cnt
//   id_instr            registered instruction
//   id_pc_plus2         registered PC+2
//   id_valid            ID slot holds a real instruction
//   id_opcode           id_instr[15:12]
//   id_rd/id_rs/id_rt   decoded register fields
//   id_reads_rs/rt      field is actually read by this instruction
//   id_is_br            valid B or BR
//   id_is_load          valid LW
//   id_halt             valid HLT held in ID
//   pc_write_en         PC may advance this cycle
//   stall_cnt           saturating count of stall cycles

module if_id_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      if_instr,
    input  logic [15:0]      if_pc_plus2,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [15:0]      id_instr,
    output logic [15:0]      id_pc_plus2,
    output logic             id_valid,
    output logic [3:0]       id_opcode,
    output logic [3:0]       id_rd,
    output logic [3:0]       id_rs,
    output logic [3:0]       id_rt,
    output logic             id_reads_rs,
    output logic             id_reads_rt,
    output logic             id_is_br,
    output logic             id_is_load,
    output logic             id_halt,
    output logic             pc_write_en,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] OpLw  = 4'b1000;
    localparam logic [3:0] OpSw  = 4'b1001;
    localparam logic [3:0] OpLlb = 4'b1010;
    localparam logic [3:0] OpLhb = 4'b1011;
    localparam logic [3:0] OpB   = 4'b1100;
    localparam logic [3:0] OpBr  = 4'b1101;
    localparam logic [3:0] OpPcs = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;
    localparam logic [3:0] OpSll = 4'b0100;
    localparam logic [3:0] OpSra = 4'b0101;
    localparam logic [3:0] OpRor = 4'b0110;

    logic [15:0]      instr_q;
    logic [15:0]      pc_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic             halt;
    logic             rs_used;
    logic             rt_used;

    assign id_instr    = instr_q;
    assign id_pc_plus2 = pc_q;
    assign id_valid    = valid_q;
    assign stall_cnt   = cnt_q;
    assign id_opcode   = instr_q[15:12];
    assign id_rd       = instr_q[11:8];

    assign halt        = valid_q && (instr_q[15:12] == OpHlt);
    assign id_halt     = halt;

    // Flush deliberately does not gate the PC: the branch target must load.
    assign pc_write_en = ~stall & ~halt;

    // Field remap and read-usage decode; fields stay live even on a bubble.
    always_comb begin
        id_rs   = instr_q[7:4];
        id_rt   = instr_q[3:0];
        rs_used = 1'b1;
        rt_used = 1'b1;
        case (instr_q[15:12])
            OpSw: begin
                id_rt = instr_q[11:8];
            end
            OpLlb, OpLhb: begin
                id_rs   = instr_q[11:8];
                rt_used = 1'b0;
            end
            OpLw, OpSll, OpSra, OpRor, OpBr: begin
                rt_used = 1'b0;
            end
            OpB, OpPcs, OpHlt: begin
                rs_used = 1'b0;
                rt_used = 1'b0;
            end
            default: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
        endcase
    end

    assign id_reads_rs = valid_q & rs_used;
    assign id_reads_rt = valid_q & rt_used;
    assign id_is_br    = valid_q & ((instr_q[15:12] == OpB) | (instr_q[15:12] == OpBr));
    assign id_is_load  = valid_q & (instr_q[15:12] == OpLw);

    // Pipeline register: flush > (stall | halt freeze) > load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 16'h0000;
            pc_q    <= 16'h0000;
            valid_q <= 1'b0;
        end else if (flush) begin
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
        end else if (!(stall || halt)) begin
            instr_q <= if_instr;
            pc_q    <= if_pc_plus2;
            valid_q <= 1'b1;
        end
    end

    // Debug stall counter: counts only real held instructions, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (stall && !flush && valid_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe with a scoreboard of expected ID contents.
module tb_if_id_pipe;

    logic        clk;
    logic        rst;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus2;
    logic        stall;
    logic        flush;
    logic        cnt_clr;

    logic [15:0] id_instr, id_pc_plus2;
    logic        id_valid;
    logic [3:0]  id_opcode, id_rd, id_rs, id_rt;
    logic        id_reads_rs, id_reads_rt, id_is_br, id_is_load, id_halt, pc_write_en;
    logic [15:0] stall_cnt;

    logic [15:0] b_instr, b_pc;
    logic        b_valid;
    logic [3:0]  b_opcode, b_rd, b_rs, b_rt;
    logic        b_reads_rs, b_reads_rt, b_is_br, b_is_load, b_halt, b_pwe;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        valid;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    exp_t sb[$];

    // Bench model of the ID register state.
    logic [15:0] m_instr, m_pc;
    logic        m_valid;
    logic [15:0] m_c16;
    logic [3:0]  m_c4;

    if_id_pipe dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc_plus2(if_pc_plus2),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .id_instr(id_instr), .id_pc_plus2(id_pc_plus2), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_reads_rs(id_reads_rs), .id_reads_rt(id_reads_rt), .id_is_br(id_is_br),
        .id_is_load(id_is_load), .id_halt(id_halt), .pc_write_en(pc_write_en),
        .stall_cnt(stall_cnt)
    );

    if_id_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc_plus2(if_pc_plus2),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .id_instr(b_instr), .id_pc_plus2(b_pc), .id_valid(b_valid),
        .id_opcode(b_opcode), .id_rd(b_rd), .id_rs(b_rs), .id_rt(b_rt),
        .id_reads_rs(b_reads_rs), .id_reads_rt(b_reads_rt), .id_is_br(b_is_br),
        .id_is_load(b_is_load), .id_halt(b_halt), .pc_write_en(b_pwe),
        .stall_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict the next ID state, compare after the edge.
    task automatic step(input logic [15:0] ins, input logic [15:0] pc,
                        input logic st, input logic fl, input logic clr);
        exp_t e;
        logic m_halt;
        if_instr    = ins;
        if_pc_plus2 = pc;
        stall       = st;
        flush       = fl;
        cnt_clr     = clr;
        m_halt = m_valid && (m_instr[15:12] == 4'hF);
        #1;
        chk("pc_write_en", {31'b0, pc_write_en}, {31'b0, ~st & ~m_halt});
        if (clr) begin
            m_c16 = 16'd0;
            m_c4  = 4'd0;
        end else if (st && !fl && m_valid) begin
            if (m_c16 != 16'hFFFF) m_c16 = m_c16 + 16'd1;
            if (m_c4 != 4'hF) m_c4 = m_c4 + 4'd1;
        end
        if (fl) begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
        end else if (!(st || m_halt)) begin
            m_instr = ins;
            m_pc    = pc;
            m_valid = 1'b1;
        end
        e.instr = m_instr;
        e.pc    = m_pc;
        e.valid = m_valid;
        e.c16   = m_c16;
        e.c4    = m_c4;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("id_instr", {16'b0, id_instr}, {16'b0, e.instr});
            chk("id_pc_plus2", {16'b0, id_pc_plus2}, {16'b0, e.pc});
            chk("id_valid", {31'b0, id_valid}, {31'b0, e.valid});
            chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, e.c16});
            chk("stall_cnt4", {28'b0, b_cnt}, {28'b0, e.c4});
        end
    endtask

    task automatic model_reset();
        m_instr = 16'h0;
        m_pc    = 16'h0;
        m_valid = 1'b0;
        m_c16   = 16'h0;
        m_c4    = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        if_instr = 16'h0;
        if_pc_plus2 = 16'h0;
        stall = 1'b0;
        flush = 1'b0;
        cnt_clr = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", {16'b0, id_instr}, 32'h0);
        chk("rst_pc", {16'b0, id_pc_plus2}, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_flags", {26'b0, id_reads_rs, id_reads_rt, id_is_br, id_is_load, id_halt,
                          ~pc_write_en}, 32'h0);
        chk("rst_cnt", {16'b0, stall_cnt}, 32'h0);
        rst = 1'b0;

        // Stream a plain ALU op
        step(16'h1123, 16'h0002, 1'b0, 1'b0, 1'b0);
        chk("alu_rd", {28'b0, id_rd}, 32'h1);
        chk("alu_rs", {28'b0, id_rs}, 32'h2);
        chk("alu_rt", {28'b0, id_rt}, 32'h3);
        chk("alu_reads", {30'b0, id_reads_rs, id_reads_rt}, 32'h3);
        chk("alu_opcode", {28'b0, id_opcode}, 32'h1);

        // LW held by a two-cycle stall
        step(16'h8245, 16'h0004, 1'b0, 1'b0, 1'b0);
        chk("lw_is_load", {31'b0, id_is_load}, 32'h1);
        chk("lw_reads", {30'b0, id_reads_rs, id_reads_rt}, 32'h2);
        step(16'h3333, 16'h0006, 1'b1, 1'b0, 1'b0);
        step(16'h4444, 16'h0008, 1'b1, 1'b0, 1'b0);
        chk("stall_hold_instr", {16'b0, id_instr}, 32'h8245);
        chk("stall_cnt_2", {16'b0, stall_cnt}, 32'h2);
        step(16'h5555, 16'h000A, 1'b0, 1'b0, 1'b0);

        // Flush beats stall
        step(16'hC123, 16'h000C, 1'b0, 1'b0, 1'b0);
        chk("b_is_br", {31'b0, id_is_br}, 32'h1);
        chk("b_reads", {30'b0, id_reads_rs, id_reads_rt}, 32'h0);
        step(16'hD000, 16'h000E, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", {31'b0, id_valid}, 32'h0);
        chk("flush_instr", {16'b0, id_instr}, 32'h0);
        chk("flush_is_br", {31'b0, id_is_br}, 32'h0);
        chk("flush_cnt", {16'b0, stall_cnt}, 32'h2);

        // SW and LLB field remap
        step(16'h9A53, 16'h0010, 1'b0, 1'b0, 1'b0);
        chk("sw_rs", {28'b0, id_rs}, 32'h5);
        chk("sw_rt", {28'b0, id_rt}, 32'hA);
        chk("sw_reads", {30'b0, id_reads_rs, id_reads_rt}, 32'h3);
        step(16'hA7FF, 16'h0012, 1'b0, 1'b0, 1'b0);
        chk("llb_rs", {28'b0, id_rs}, 32'h7);
        chk("llb_reads", {30'b0, id_reads_rs, id_reads_rt}, 32'h2);

        // BR reads RS only
        step(16'hD040, 16'h0014, 1'b0, 1'b0, 1'b0);
        chk("br_flags", {29'b0, id_is_br, id_reads_rs, id_reads_rt}, 32'h6);

        // Halt freeze, then flush releases it
        step(16'hF000, 16'h0016, 1'b0, 1'b0, 1'b0);
        chk("hlt_halt", {31'b0, id_halt}, 32'h1);
        chk("hlt_pwe", {31'b0, pc_write_en}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(16'h2000 + 16'(i * 16'h0111), 16'h0018 + 16'(2 * i), 1'b0, 1'b0, 1'b0);
            chk("hlt_frozen", {16'b0, id_instr}, 32'hF000);
        end
        step(16'h1111, 16'h0030, 1'b0, 1'b1, 1'b0);
        chk("hlt_flush_valid", {31'b0, id_valid}, 32'h0);
        chk("hlt_flush_halt", {31'b0, id_halt}, 32'h0);
        step(16'h2345, 16'h0032, 1'b0, 1'b0, 1'b0);
        chk("hlt_next_load", {16'b0, id_instr}, 32'h2345);

        // Saturation of the 4-bit counter, then clear while stalled
        step(16'h0000, 16'h0034, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(16'h7777, 16'h0036, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_cnt4", {28'b0, b_cnt}, 32'hF);
        chk("sat_cnt16", {16'b0, stall_cnt}, 32'd20);
        step(16'h7777, 16'h0036, 1'b1, 1'b0, 1'b1);
        chk("clr_cnt4", {28'b0, b_cnt}, 32'h0);

        // Asynchronous reset between edges
        step(16'h3456, 16'h0040, 1'b1, 1'b0, 1'b0);
        step(16'h3456, 16'h0040, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, id_valid}, 32'h0);
        chk("arst_instr", {16'b0, id_instr}, 32'h0);
        chk("arst_cnt", {16'b0, stall_cnt}, 32'h0);
        rst = 1'b0;
        model_reset();
        step(16'h0abc, 16'h0042, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

IF/ID pipeline register for the 16-bit, 16-register pipeline. It captures the fetched instruction and PC+2, honours the decode-stage `stall` from the data-hazard unit and the `flush` from taken branches, and decodes the register fields the hazard unit and register file consume (RS, RT, RD, branch/load flags). It also owns halt freezing, the PC write-enable, and a saturating stall-cycle counter for debug.

## Interface
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `if_instr`  in  16: instruction fetched this cycle.
- `if_pc_plus2`  in  16: PC+2 of the fetched instruction.
- `stall`  in  1: hold request from the data-hazard unit.
- `flush`  in  1: squash request from a taken branch.
- `cnt_clr`  in  1: synchronous clear of `stall_cnt`.
- `id_instr`  out  16: registered instruction.
- `id_pc_plus2`  out  16: registered PC+2.
- `id_valid`  out  1: ID slot holds a real instruction.
- `id_opcode`  out  4: `id_instr[15:12]`.
- `id_rd`  out  4: destination register field.
- `id_rs`  out  4: source register 1.
- `id_rt`  out  4: source register 2.
- `id_reads_rs`, `id_reads_rt`  out  1 each: the field is actually read.
- `id_is_br`  out  1: valid B (`1100`) or BR (`1101`).
- `id_is_load`  out  1: valid LW (`1000`).
- `id_halt`  out  1: valid HLT (`1111`) held in ID.
- `pc_write_en`  out  1: PC may advance this cycle.
- `stall_cnt`  out  CNT_W: saturating count of stall cycles.

## Operation
- **Field decode** is combinational from the registered instruction.
  - `id_rd = [11:8]`.
  - Default `id_rs = [7:4]`, `id_rt = [3:0]`.
  - SW (`1001`): `id_rt = [11:8]`, reads RS and RT.
  - LLB/LHB (`1010`/`1011`): `id_rs = [11:8]`, reads RS only.
  - LW and shifts/rotate (`0100`–`0110`): read RS only.
  - B (`1100`): reads neither field.
  - BR (`1101`): reads RS only.
  - PCS (`1110`) and HLT: read neither field.
  - Remaining ALU ops read both fields.
- **Masking:** when `id_valid=0`, all `reads_*`, `is_*` and `halt` flags are 0. Field outputs still reflect `id_instr`.
- **Update priority each edge:**
  1. `flush`: load a bubble (`id_valid=0`, `id_instr=16'h0000`, `id_pc_plus2` unchanged).
  2. `stall` or `id_halt`: hold all registers.
  3. Otherwise: load `if_instr` and `if_pc_plus2`, and set `id_valid=1`.
- **Halt freeze:** once a valid HLT is in ID, the register stays frozen until a `flush` or `rst`. A flush clears the freeze, because the HLT was on a wrong path.
- **PC enable:** `pc_write_en = ~stall & ~id_halt`. It is combinational. `flush` does not gate it, since the branch target must load.
- **Stall counter:**
  - Increments on each edge where `stall=1`, `flush=0` and `id_valid=1`.
  - Saturates at all-ones; it never wraps.
  - `cnt_clr` has priority over increment; after a clear the count is 0.

## Timing
- **Reset values:**
  - `id_instr=0`, `id_pc_plus2=0`, `id_valid=0`, `stall_cnt=0`.
  - All flags 0, `pc_write_en=1`.
- **Latency:** 1 cycle from IF to ID outputs. Decoded fields are valid in the same cycle as `id_instr`.
- **Stall loop:** `stall` is produced combinationally from `id_rs`/`id_rt`, which come from registers. There is no combinational loop through this block.
- **Stall duration:** a stall asserted for N cycles holds the ID contents for exactly N edges. The same instruction reaches ID outputs on N+1 consecutive cycles.
- **Simultaneous `flush` and `stall`:** flush wins, and the bubble appears the next cycle. `stall_cnt` does not increment.
- **Reset mid-operation:** asynchronous. Outputs take reset values immediately, independent of `clk`.

## Test plan
- **Reset, then stream:** release `rst`; present `if_instr=16'h1123`, `if_pc_plus2=16'h0002`; next edge.
  - Expect `id_valid=1`, `id_rd=1`, `id_rs=2`, `id_rt=3`, both reads=1, `pc_write_en=1`.
- **Stall hold:** with `16'h8245` (LW) in ID, assert `stall` for 2 cycles while `if_instr` changes.
  - Expect `id_instr` to stay `8245` for 3 cycles.
  - Expect `pc_write_en=0` during the stall and `stall_cnt=2`.
- **Flush beats stall:** assert `stall` and `flush` together.
  - Next cycle expect `id_valid=0`, `id_instr=0`, `id_is_br=0`.
  - Expect `stall_cnt` unchanged.
- **SW and LLB field remap:**
  - `16'h9A53` (SW): expect `id_rs=5`, `id_rt=A`.
  - `16'hA7FF` (LLB): expect `id_rs=7`, `reads_rt=0`.
- **Halt freeze:** load `16'hF000`.
  - Expect `id_halt=1`, `pc_write_en=0`, and ID held for 5 cycles regardless of `if_instr`.
  - Then pulse `flush`: expect `id_valid=0`, `id_halt=0`, and the next instruction loads.
- **Counter saturation and clear:** with `CNT_W=4`, hold `stall` for 20 cycles.
  - Expect `stall_cnt=15`.
  - Pulse `cnt_clr` with `stall=1`: expect 0.
